// File: rtl/branch_history_table.sv
// branch_history_table
// Dynamic branch predictor built from 2-bit saturating counters indexed by PC.
// The ID stage reads the table combinationally to get a taken/not-taken
// prediction. The EX stage writes the resolved outcome back one edge later.
// The mispredict flag is derived from the prediction carried down the
// pipeline, not from the live table, so that flush decisions match what ID
// actually fetched. Two saturating statistics counters track resolved
// branches and mispredictions for performance measurement.

module branch_history_table #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             predict_o,
    input  logic             resolve_valid_i,
    input  logic [31:0]      resolve_pc_i,
    input  logic             resolve_predict_i,
    input  logic             resolve_taken_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] branch_count_o,
    output logic [CNT_W-1:0] mispredict_count_o
);

    localparam int DEPTH = 1 << INDEX_BITS;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;
    localparam logic [1:0] CTR_STEP      = 2'b01;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Move a 2-bit predictor counter one step toward the observed outcome,
    // saturating at either end.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr,
                                            input logic       taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_STRONG_T) begin
                res = ctr + CTR_STEP;
            end else begin
                res = ctr;
            end
        end else begin
            if (ctr != CTR_STRONG_NT) begin
                res = ctr - CTR_STEP;
            end else begin
                res = ctr;
            end
        end
        return res;
    endfunction

    // Increment a statistics counter, holding at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val != CNT_MAX) begin
            res = val + CNT_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // State
    logic [1:0]       r_table [DEPTH];
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // Combinational helpers
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_resolve_idx;
    logic [1:0]            w_lookup_ctr;
    logic [1:0]            w_resolve_ctr;
    logic [1:0]            w_resolve_ctr_nxt;
    logic                  w_mispredict;
    logic [CNT_W-1:0]      w_branch_count_nxt;
    logic [CNT_W-1:0]      w_mispredict_count_nxt;
    logic                  w_unused_pc_bits;

    // Only the index field of each PC selects a table entry; the remaining
    // bits are deliberately dropped, so PCs that share an index alias.
    assign w_lookup_idx  = lookup_pc_i[INDEX_BITS+1:2];
    assign w_resolve_idx = resolve_pc_i[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{lookup_pc_i[31:INDEX_BITS+2], lookup_pc_i[1:0],
                                resolve_pc_i[31:INDEX_BITS+2], resolve_pc_i[1:0]};

    // Table reads: prediction for ID and current state of the entry being resolved.
    always_comb begin
        w_lookup_ctr      = r_table[w_lookup_idx];
        w_resolve_ctr     = r_table[w_resolve_idx];
        w_resolve_ctr_nxt = ctr_step(w_resolve_ctr, resolve_taken_i);
    end

    // Mispredict compares the carried prediction against the actual outcome;
    // an invalid (flushed) slot never flags.
    always_comb begin
        w_mispredict = 1'b0;
        if (resolve_valid_i) begin
            w_mispredict = (resolve_predict_i != resolve_taken_i);
        end else begin
            w_mispredict = 1'b0;
        end
    end

    // Next values for the statistics counters.
    always_comb begin
        w_branch_count_nxt     = r_branch_count;
        w_mispredict_count_nxt = r_mispredict_count;
        if (resolve_valid_i) begin
            w_branch_count_nxt = sat_inc(r_branch_count);
            if (w_mispredict) begin
                w_mispredict_count_nxt = sat_inc(r_mispredict_count);
            end else begin
                w_mispredict_count_nxt = r_mispredict_count;
            end
        end else begin
            w_branch_count_nxt     = r_branch_count;
            w_mispredict_count_nxt = r_mispredict_count;
        end
    end

    // Predictor table: reset to strongly taken, then train on each resolved branch.
    // No write-through bypass: a same-cycle lookup sees the pre-update value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_STRONG_T;
            end
        end else if (resolve_valid_i) begin
            r_table[w_resolve_idx] <= w_resolve_ctr_nxt;
        end
    end

    // Statistics counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branch_count     <= CNT_ZERO;
            r_mispredict_count <= CNT_ZERO;
        end else begin
            r_branch_count     <= w_branch_count_nxt;
            r_mispredict_count <= w_mispredict_count_nxt;
        end
    end

    // Prediction and mispredict must be zero-latency, so they leave the block
    // combinationally; the counts come straight from registers.
    assign predict_o          = w_lookup_ctr[1];
    assign mispredict_o       = w_mispredict;
    assign branch_count_o     = r_branch_count;
    assign mispredict_count_o = r_mispredict_count;

endmodule
